// File: rtl/pulse_pkg.sv
// Shared types for the pulse scheduler and pulse engine: descriptor payload, scheduler states, widths.
package pulse_pkg;

  localparam int unsigned PHASE_W    = 32;
  localparam int unsigned AMP_W      = 16;
  localparam int unsigned PHOFS_W    = 16;
  localparam int unsigned TSTART_W   = 24;
  localparam int unsigned TLEN_W     = 16;
  localparam int unsigned ENV_ADDR_W = 16;
  localparam int unsigned TIME_W     = 32;
  localparam int unsigned LATE_W     = 16;

  typedef struct packed {
    logic [PHASE_W-1:0]    fcw;
    logic [PHOFS_W-1:0]    phase;
    logic [AMP_W-1:0]      amp;
    logic [TSTART_W-1:0]   t_start;
    logic [TLEN_W-1:0]     t_len;
    logic [ENV_ADDR_W-1:0] env_addr;
  } pulse_desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BUSY = 2'd2
  } sched_state_t;

  // Wraparound distance from now to start; MSB set means start is already in the past.
  function automatic logic [TSTART_W-1:0] time_delta(input logic [TSTART_W-1:0] t_start,
                                                     input logic [TSTART_W-1:0] now);
    return t_start - now;
  endfunction

endpackage

// File: rtl/pulse_scheduler_if.sv
// Descriptor push port: CPU side is master, scheduler side is slave.
interface pulse_scheduler_if;
  import pulse_pkg::*;

  logic        s_desc_valid;
  logic        s_desc_ready;
  pulse_desc_t s_desc;

  modport master (output s_desc_valid, output s_desc, input s_desc_ready);
  modport slave  (input s_desc_valid, input s_desc, output s_desc_ready);

endinterface

// File: rtl/pulse_desc_fifo.sv
// Synchronous descriptor FIFO with a registered show-ahead head and single-cycle flush.
module pulse_desc_fifo
  import pulse_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  pulse_desc_t   wdata,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output pulse_desc_t   head
);

  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_left;
  pulse_desc_t   mem_q [DEPTH];
  pulse_desc_t   head_q;
  pulse_desc_t   head_d;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = head_q;
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Next head: the incoming word when the queue drains to it, otherwise the stored entry.
  always_comb begin
    rd_nxt   = rd_q + AW'(pop_ok);
    cnt_left = cnt_q - CW'(pop_ok);
    cnt_d    = flush ? '0 : cnt_left + CW'(push_ok);
    head_d   = head_q;
    if (push_ok || pop_ok) begin
      head_d = (cnt_left == '0) ? wdata : mem_q[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_q + AW'(push_ok);
        rd_q <= rd_nxt;
      end
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Timed descriptor queue that issues one-cycle pulse_ready strobes to the pulse engine.
// Optional build macro PULSE_SCHED_LATE_DROP_EN: late heads are discarded instead of issued.
module pulse_scheduler
  import pulse_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pulse_scheduler_if.slave      s_desc_if,
  input  logic [TIME_W-1:0]     time_counter,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  pulse_ready,
  output logic [PHASE_W-1:0]    freq_trig,
  output logic [PHOFS_W-1:0]    phase_trig,
  output logic [AMP_W-1:0]      amp_trig,
  output logic [TSTART_W-1:0]   t_start_trig,
  output logic [TLEN_W-1:0]     t_len_trig,
  output logic [ENV_ADDR_W-1:0] env_addr_trig,
  output logic [CW-1:0]         fifo_count,
  output logic                  engine_busy,
  output logic [LATE_W-1:0]     late_cnt
);

  sched_state_t          state_q, state_d;
  pulse_desc_t           head;
  pulse_desc_t           trig_q, trig_d;
  logic                  fifo_full, fifo_empty;
  logic [TSTART_W-1:0]   delta_c;
  logic                  due_c, late_c, eligible_c, issue_c, drop_c, pop_c;
  logic [TLEN_W-1:0]     len_c;
  logic                  hold_done_c;
  logic [TLEN_W-1:0]     hold_q, hold_d;
  logic                  pulse_ready_q, pulse_ready_d;
  logic                  busy_q, busy_d;
  logic [LATE_W-1:0]     late_q, late_d;
  logic                  unused_tc_hi;

  assign unused_tc_hi           = ^time_counter[TIME_W-1:TSTART_W];
  assign s_desc_if.s_desc_ready = !fifo_full && !flush;

  pulse_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_desc_if.s_desc_valid),
    .wdata (s_desc_if.s_desc),
    .pop   (pop_c),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  // Due/late decode of the head against the low time bits; flush outranks any issue.
  always_comb begin
    delta_c     = time_delta(head.t_start, time_counter[TSTART_W-1:0]);
    late_c      = delta_c[TSTART_W-1];
    due_c       = late_c || (delta_c == '0);
    eligible_c  = (state_q == WAIT) && !fifo_empty && enable && !flush;
    len_c       = (head.t_len == '0) ? TLEN_W'(1) : head.t_len;
    hold_done_c = (hold_q <= TLEN_W'(1));
`ifdef PULSE_SCHED_LATE_DROP_EN
    issue_c     = eligible_c && due_c && !late_c;
    drop_c      = eligible_c && late_c;
`else
    issue_c     = eligible_c && due_c;
    drop_c      = 1'b0;
`endif
    pop_c       = issue_c || drop_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A one-cycle pulse needs no hold-off, so it stays in WAIT to allow issue on the very next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!fifo_empty && !flush) state_d = WAIT;
      WAIT: begin
        if (issue_c)                  state_d = (len_c == TLEN_W'(1)) ? WAIT : BUSY;
        else if (flush || fifo_empty) state_d = IDLE;
      end
      BUSY: if (hold_done_c)          state_d = (fifo_empty || flush) ? IDLE : WAIT;
      default:                        state_d = IDLE;
    endcase
  end

  // Hold-off is loaded with L-1 so the next WAIT cycle lands exactly L cycles after issue.
  always_comb begin
    pulse_ready_d = 1'b0;
    trig_d        = trig_q;
    hold_d        = hold_q;
    late_d        = late_q;
    busy_d        = (state_d == BUSY);
    if ((state_q == BUSY) && (hold_q != '0)) begin
      hold_d = hold_q - TLEN_W'(1);
    end
    if (issue_c) begin
      pulse_ready_d = 1'b1;
      trig_d        = head;
      hold_d        = len_c - TLEN_W'(1);
    end
    if (pop_c && late_c && (late_q != '1)) begin
      late_d = late_q + LATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_ready_q <= 1'b0;
      trig_q        <= '0;
      hold_q        <= '0;
      late_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      pulse_ready_q <= pulse_ready_d;
      trig_q        <= trig_d;
      hold_q        <= hold_d;
      late_q        <= late_d;
      busy_q        <= busy_d;
    end
  end

  assign pulse_ready   = pulse_ready_q;
  assign freq_trig     = trig_q.fcw;
  assign phase_trig    = trig_q.phase;
  assign amp_trig      = trig_q.amp;
  assign t_start_trig  = trig_q.t_start;
  assign t_len_trig    = trig_q.t_len;
  assign env_addr_trig = trig_q.env_addr;
  assign engine_busy   = busy_q;
  assign late_cnt      = late_q;

endmodule
